// File: rtl/darkbus_arb_pkg.sv
// rtl/darkbus_arb_pkg.sv - shared types and defaults for the darkbus two-requester arbiter
package darkbus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2,
      REC   = 2'd3
   } state_t;

   typedef enum logic {
      M_I = 1'b0,
      M_D = 1'b1
   } master_t;

   localparam logic [31:0] DEF_ERRDATA = 32'hDEAD_BEEF;
   localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/darkbus_arb_wdt.sv
// rtl/darkbus_arb_wdt.sv - grant watchdog counter, fires when a transaction stalls for limit cycles
module darkbus_arb_wdt (
   input  logic        clk,
   input  logic        res,
   input  logic        clr,
   input  logic        inc,
   input  logic [15:0] limit,
   output logic        expired
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // clear while no grant is held, count stalled grant cycles otherwise
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // counter register
   always_ff @(posedge clk) begin
      if (!res) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // fires in the stalled cycle that brings the count up to the limit
   assign expired = inc && !clr && ((cnt_q + 16'd1) == limit);

endmodule

// File: rtl/darkbus_arb.sv
// rtl/darkbus_arb.sv - darkbus I/D arbiter, optional watchdog under DARKBUS_ARB_WDT_EN
module darkbus_arb
   import darkbus_arb_pkg::*;
#(
   parameter int          FAIR    = 1,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT,
   parameter logic [31:0] ERRDATA = DEF_ERRDATA
) (
   input  logic        clk,
   input  logic        res,
   input  logic        ibus_en,
   input  logic        ibus_rw,
   input  logic [3:0]  ibus_be,
   input  logic [31:0] ibus_addr,
   input  logic [31:0] ibus_wdata,
   output logic [31:0] ibus_rdata,
   output logic        ibus_valid,
   input  logic        dbus_en,
   input  logic        dbus_rw,
   input  logic [3:0]  dbus_be,
   input  logic [31:0] dbus_addr,
   input  logic [31:0] dbus_wdata,
   output logic [31:0] dbus_rdata,
   output logic        dbus_valid,
   output logic        mbus_en,
   output logic        mbus_rw,
   output logic [3:0]  mbus_be,
   output logic [31:0] mbus_addr,
   output logic [31:0] mbus_wdata,
   input  logic [31:0] mbus_rdata,
   input  logic        mbus_valid,
   output logic [1:0]  gnt,
   output logic        err
);

   localparam logic [15:0] WDT_LIMIT = TIMEOUT[15:0];

   state_t      state_q;
   state_t      state_d;
   master_t     last_q;
   master_t     last_d;
   logic        err_q;
   logic        err_d;
   logic        own_i;
   logic        own_d;
   logic        granted;
   logic        sel_en;
   logic        sel_rw;
   logic [3:0]  sel_be;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        wdt_exp;
   logic        finish;
   logic [31:0] ret_data;

   assign own_i   = (state_q == GNT_I);
   assign own_d   = (state_q == GNT_D);
   assign granted = own_i || own_d;

   // pick the current owner's request fields; all zero when nobody owns the bus
   always_comb begin
      sel_en    = 1'b0;
      sel_rw    = 1'b0;
      sel_be    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (own_i) begin
         sel_en    = ibus_en;
         sel_rw    = ibus_rw;
         sel_be    = ibus_be;
         sel_addr  = ibus_addr;
         sel_wdata = ibus_wdata;
      end else if (own_d) begin
         sel_en    = dbus_en;
         sel_rw    = dbus_rw;
         sel_be    = dbus_be;
         sel_addr  = dbus_addr;
         sel_wdata = dbus_wdata;
      end
   end

`ifdef DARKBUS_ARB_WDT_EN
   darkbus_arb_wdt u_wdt (
      .clk     (clk),
      .res     (res),
      .clr     (!granted),
      .inc     (granted && sel_en && !mbus_valid),
      .limit   (WDT_LIMIT),
      .expired (wdt_exp)
   );
`else
   logic unused_wdt_limit;
   assign unused_wdt_limit = ^WDT_LIMIT;
   assign wdt_exp          = 1'b0;
`endif

   // a real memory response always beats a coinciding timeout
   assign finish   = mbus_valid || wdt_exp;
   assign ret_data = wdt_exp ? ERRDATA : mbus_rdata;

   assign mbus_en    = sel_en && !wdt_exp;
   assign mbus_rw    = sel_rw;
   assign mbus_be    = sel_be;
   assign mbus_addr  = sel_addr;
   assign mbus_wdata = (granted && sel_rw) ? sel_wdata : 'z;

   assign ibus_valid = own_i && finish;
   assign dbus_valid = own_d && finish;
   assign ibus_rdata = (own_i && !ibus_rw) ? ret_data : 'z;
   assign dbus_rdata = (own_d && !dbus_rw) ? ret_data : 'z;

   assign gnt = {own_d, own_i};
   assign err = err_q;

   // grant selection, completion and the one-cycle recovery slot
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (ibus_en && dbus_en) begin
               state_d = ((FAIR == 0) || (last_q == M_I)) ? GNT_D : GNT_I;
            end else if (dbus_en) begin
               state_d = GNT_D;
            end else if (ibus_en) begin
               state_d = GNT_I;
            end
         end
         GNT_I, GNT_D: begin
            if (!sel_en) begin
               state_d = IDLE;
            end else if (mbus_valid) begin
               state_d = REC;
               last_d  = own_d ? M_D : M_I;
            end else if (wdt_exp) begin
               state_d = REC;
               err_d   = 1'b1;
            end
         end
         REC:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // arbiter state registers
   always_ff @(posedge clk) begin
      if (!res) begin
         state_q <= IDLE;
         last_q  <= M_I;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_darkbus_arb.sv
// tb/tb_darkbus_arb.sv - directed and randomized checks of darkbus_arb against a transaction model
module tb_darkbus_arb;

   localparam int          TMO  = 8;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        res;
   logic        i_en, i_rw, d_en, d_rw, m_valid;
   logic [3:0]  i_be, d_be;
   logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_rdata;
   wire  [31:0] i_rdata, d_rdata, mo_addr, mo_wdata;
   wire         i_valid, d_valid, mo_en, mo_rw, err;
   wire  [3:0]  mo_be;
   wire  [1:0]  gnt;
   wire  [31:0] i_rdata0, d_rdata0, mo_addr0, mo_wdata0;
   wire         i_valid0, d_valid0, mo_en0, mo_rw0, err0;
   wire  [3:0]  mo_be0;
   wire  [1:0]  gnt0;

   int n_cmp = 0;
   int n_bad = 0;

   // transaction model: who owns the bus (0 none, 1 I, 2 D), recovery slot, last served, stall cycles
   int m_owner, m_last, m_cnt;
   bit m_rec, m_err, mk;
   bit got_i, got_d;

   always #5 clk = ~clk;

   darkbus_arb #(.FAIR(1), .TIMEOUT(TMO), .ERRDATA(ERRD)) dut (
      .clk(clk), .res(res),
      .ibus_en(i_en), .ibus_rw(i_rw), .ibus_be(i_be), .ibus_addr(i_addr),
      .ibus_wdata(i_wdata), .ibus_rdata(i_rdata), .ibus_valid(i_valid),
      .dbus_en(d_en), .dbus_rw(d_rw), .dbus_be(d_be), .dbus_addr(d_addr),
      .dbus_wdata(d_wdata), .dbus_rdata(d_rdata), .dbus_valid(d_valid),
      .mbus_en(mo_en), .mbus_rw(mo_rw), .mbus_be(mo_be), .mbus_addr(mo_addr),
      .mbus_wdata(mo_wdata), .mbus_rdata(m_rdata), .mbus_valid(m_valid),
      .gnt(gnt), .err(err)
   );

   darkbus_arb #(.FAIR(0), .TIMEOUT(TMO), .ERRDATA(ERRD)) dut0 (
      .clk(clk), .res(res),
      .ibus_en(i_en), .ibus_rw(i_rw), .ibus_be(i_be), .ibus_addr(i_addr),
      .ibus_wdata(i_wdata), .ibus_rdata(i_rdata0), .ibus_valid(i_valid0),
      .dbus_en(d_en), .dbus_rw(d_rw), .dbus_be(d_be), .dbus_addr(d_addr),
      .dbus_wdata(d_wdata), .dbus_rdata(d_rdata0), .dbus_valid(d_valid0),
      .mbus_en(mo_en0), .mbus_rw(mo_rw0), .mbus_be(mo_be0), .mbus_addr(mo_addr0),
      .mbus_wdata(mo_wdata0), .mbus_rdata(m_rdata), .mbus_valid(m_valid),
      .gnt(gnt0), .err(err0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // check one cycle against the model, advance the model, return at the next falling edge
   task automatic step();
      logic [1:0]  eg;
      logic        xen, xrw, expire, ev_i, ev_d;
      logic [3:0]  xbe;
      logic [31:0] xaddr, xwd;
      #1;
      got_i = 1'b0;
      got_d = 1'b0;
      if (mk) begin
         eg    = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
         xen   = (m_owner == 1) ? i_en    : (m_owner == 2) ? d_en    : 1'b0;
         xrw   = (m_owner == 1) ? i_rw    : (m_owner == 2) ? d_rw    : 1'b0;
         xbe   = (m_owner == 1) ? i_be    : (m_owner == 2) ? d_be    : 4'h0;
         xaddr = (m_owner == 1) ? i_addr  : (m_owner == 2) ? d_addr  : 32'h0;
         xwd   = (m_owner == 1) ? i_wdata : (m_owner == 2) ? d_wdata : 32'h0;
         expire = 1'b0;
`ifdef DARKBUS_ARB_WDT_EN
         expire = (m_owner != 0) && xen && !m_valid && (m_cnt + 1 == TMO);
`endif
         ev_i = (m_owner == 1) && (m_valid || expire);
         ev_d = (m_owner == 2) && (m_valid || expire);
         chk("gnt", gnt, eg);
         chk("mbus_en", mo_en, xen && !expire);
         chk("mbus_rw", mo_rw, xrw);
         chk("mbus_be", mo_be, xbe);
         chk("mbus_addr", mo_addr, xaddr);
         if (m_owner != 0 && xrw) chk("mbus_wdata", mo_wdata, xwd);
         chk("ibus_valid", i_valid, ev_i);
         chk("dbus_valid", d_valid, ev_d);
         if (ev_i && !i_rw) chk("ibus_rdata", i_rdata, expire ? ERRD : m_rdata);
         if (ev_d && !d_rw) chk("dbus_rdata", d_rdata, expire ? ERRD : m_rdata);
         chk("err", err, m_err);
         got_i = ev_i;
         got_d = ev_d;
         if (m_owner != 0) begin
            if (!xen) begin
               m_owner = 0;
            end else if (m_valid) begin
               m_rec = 1; m_last = m_owner; m_owner = 0;
            end else if (expire) begin
               m_rec = 1; m_err = 1; m_owner = 0;
            end else begin
               m_cnt++;
            end
         end else if (m_rec) begin
            m_rec = 0;
         end else begin
            m_cnt = 0;
            if (i_en && d_en) m_owner = (m_last == 1) ? 2 : 1;
            else if (d_en)    m_owner = 2;
            else if (i_en)    m_owner = 1;
         end
      end
      if (!res) begin
         m_owner = 0; m_rec = 0; m_last = 1; m_cnt = 0; m_err = 0; mk = 1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      res = 1'b0;
      step();
      res = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int nd, at;
      bit seen;
      res = 1'b0; mk = 0;
      i_en = 0; i_rw = 0; i_be = 4'h0; i_addr = 0; i_wdata = 0;
      d_en = 0; d_rw = 0; d_be = 4'h0; d_addr = 0; d_wdata = 0;
      m_valid = 0; m_rdata = 0;
      @(negedge clk);
      step();
      do_reset();
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_err", err, 1'b0);
      chk("rst_mbus_en", mo_en, 1'b0);

      // single instruction fetch
      i_en = 1; i_rw = 0; i_be = 4'hF; i_addr = 32'h0000_0100;
      step();
      chk("t1_gnt", gnt, 2'b01);
      chk("t1_addr", mo_addr, 32'h0000_0100);
      m_valid = 1; m_rdata = 32'h0000_0013;
      #1;
      chk("t1_ivalid", i_valid, 1'b1);
      chk("t1_idata", i_rdata, 32'h0000_0013);
      chk("t1_dvalid", d_valid, 1'b0);
      step();
      i_en = 0; m_valid = 0;
      step(); step();

      // tie after reset with round-robin: D first, I three cycles after D completes
      do_reset();
      i_en = 1; d_en = 1; d_rw = 0; d_addr = 32'h0000_2000; d_be = 4'hF;
      step();
      chk("t2_d_first", gnt, 2'b10);
      m_valid = 1; m_rdata = 32'h1234_5678;
      step();
      d_en = 0; m_valid = 0;
      step();
      chk("t2_rec_gnt", gnt, 2'b00);
      d_en = 1;
      step();
      step();
      chk("t2_i_next_tie", gnt, 2'b01);
      m_valid = 1; m_rdata = 32'h0000_0093;
      step();
      i_en = 0; m_valid = 0;
      step(); step();
      chk("t2_d_again", gnt, 2'b10);
      m_valid = 1;
      step();
      d_en = 0; m_valid = 0;
      step(); step();

      // fixed priority: D holding en starves I
      do_reset();
      i_en = 1; d_en = 1; m_valid = 1;
      nd = 0;
      for (int k = 0; k < 12; k++) begin
         chk("t3_no_i_grant", gnt0 == 2'b01, 1'b0);
         chk("t3_no_i_valid", i_valid0, 1'b0);
         if (gnt0 == 2'b10) nd++;
         step();
      end
      chk("t3_d_grants", nd, 4);
      i_en = 0; d_en = 0; m_valid = 0;
      step(); step(); step();

      // data write steering
      do_reset();
      d_en = 1; d_rw = 1; d_addr = 32'h4000_0010; d_wdata = 32'hCAFE_F00D; d_be = 4'hF;
      step();
      chk("t4_gnt", gnt, 2'b10);
      chk("t4_addr", mo_addr, 32'h4000_0010);
      chk("t4_wdata", mo_wdata, 32'hCAFE_F00D);
      chk("t4_be", mo_be, 4'hF);
      chk("t4_rw", mo_rw, 1'b1);
      step();
      chk("t4_rw_hold", mo_rw, 1'b1);
      m_valid = 1;
      step();
      d_en = 0; d_rw = 0; m_valid = 0;
      step(); step();

      // read to a target that never answers
      do_reset();
      d_en = 1; d_rw = 0; d_addr = 32'h5000_0000;
      step();
`ifdef DARKBUS_ARB_WDT_EN
      seen = 0; at = 0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         #1;
         if (d_valid === 1'b1) begin
            seen = 1; at = k;
            chk("t5_errdata", d_rdata, ERRD);
         end
         step();
      end
      chk("t5_timeout_cycle", at, TMO);
      d_en = 0;
      step(); step();
      chk("t5_err_set", err, 1'b1);
      step(); step();
      chk("t5_err_sticky", err, 1'b1);
      do_reset();
      chk("t5_err_cleared", err, 1'b0);
`else
      seen = 0; at = 0;
      for (int k = 0; k < 20; k++) step();
      chk("t5_held", gnt, 2'b10);
      chk("t5_no_err", err, 1'b0);
      m_valid = 1;
      step();
      d_en = 0; m_valid = 0;
      step(); step();
`endif

      // reset in the middle of an I grant
      do_reset();
      i_en = 1; i_rw = 0; i_addr = 32'h0000_0200;
      step();
      chk("t6_gnt", gnt, 2'b01);
      res = 0;
      step();
      res = 1; m_valid = 1; m_rdata = 32'h0000_0073;
      #1;
      chk("t6_gnt_rst", gnt, 2'b00);
      chk("t6_men_rst", mo_en, 1'b0);
      chk("t6_ivalid_rst", i_valid, 1'b0);
      chk("t6_dvalid_rst", d_valid, 1'b0);
      step();
      chk("t6_regrant", gnt, 2'b01);
      step();
      i_en = 0; m_valid = 0;
      step(); step();

      // randomized traffic from both requesters
      do_reset();
      for (int k = 0; k < 400; k++) begin
         if (got_i) i_en = 0;
         else if (!i_en && $urandom_range(0, 2) == 0) begin
            i_en = 1; i_rw = 1'($urandom_range(0, 1)); i_be = 4'($urandom);
            i_addr = $urandom; i_wdata = $urandom;
         end
         if (got_d) d_en = 0;
         else if (!d_en && $urandom_range(0, 2) == 0) begin
            d_en = 1; d_rw = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
            d_addr = $urandom; d_wdata = $urandom;
         end
         m_valid = ($urandom_range(0, 2) == 0);
         m_rdata = $urandom;
         step();
      end
      i_en = 0; d_en = 0; m_valid = 0;
      step(); step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
